// File: rtl/instr_fetch_unit.sv
// Two-slot instruction word buffer with next-word prefetch between program memory
// and the control unit. Define FETCH_STATS_EN to add the hit_count/miss_count outputs.
module instr_fetch_unit #(
  parameter int PC_W    = 16,
  parameter int WADDR_W = PC_W - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc,
  input  logic               flush,
  output logic [0:15]        raw_instruction,
  output logic               instr_valid,
  output logic               mem_req,
  output logic [WADDR_W-1:0] mem_addr,
  input  logic               mem_ack,
  input  logic [31:0]        mem_rdata,
  output logic               busy
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         valid_q, valid_d;
  logic [WADDR_W-1:0] tag_q  [2];
  logic [WADDR_W-1:0] tag_d  [2];
  logic [31:0]        data_q [2];
  logic [31:0]        data_d [2];
  logic               mru_q, mru_d;
  logic               target_q, target_d;
  logic               discard_q, discard_d;
  logic [WADDR_W-1:0] addr_q, addr_d;

  logic [WADDR_W-1:0] word_addr_s;
  logic [WADDR_W-1:0] next_addr_s;
  logic [1:0]         hit_s;
  logic [1:0]         next_match_s;
  logic               any_hit_s;
  logic               hit_slot_s;
  logic               next_held_s;
  logic               fill_slot_s;
  logic [31:0]        hit_word_s;

  // Victim for a demand miss: an empty slot first, otherwise the one not used last.
  function automatic logic pick_victim(input logic [1:0] valid, input logic mru);
    logic victim;
    if (!valid[0]) begin
      victim = 1'b0;
    end else if (!valid[1]) begin
      victim = 1'b1;
    end else begin
      victim = ~mru;
    end
    return victim;
  endfunction

  assign word_addr_s = pc[PC_W-1:1];
  assign next_addr_s = word_addr_s + WADDR_W'(1);

  // Tag compare of both slots against the current and the following word.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit_s[i]        = valid_q[i] && (tag_q[i] == word_addr_s);
      next_match_s[i] = valid_q[i] && (tag_q[i] == next_addr_s);
    end
  end

  assign any_hit_s   = |hit_s;
  assign hit_slot_s  = ~hit_s[0];
  assign next_held_s = |next_match_s;
  assign hit_word_s  = hit_s[0] ? data_q[0] : data_q[1];
  // Never overwrite the slot the control unit is reading right now.
  assign fill_slot_s = (any_hit_s && (hit_slot_s == target_q)) ? ~target_q : target_q;

  // Zero-cycle instruction select from the hitting slot.
  always_comb begin
    raw_instruction = 16'h0000;
    instr_valid     = any_hit_s;
    if (any_hit_s) begin
      if (pc[0]) begin
        raw_instruction = hit_word_s[15:0];
      end else begin
        raw_instruction = hit_word_s[31:16];
      end
    end else begin
      raw_instruction = 16'h0000;
    end
  end

  assign mem_req  = (state_q == S_REQ);
  assign busy     = (state_q == S_REQ);
  assign mem_addr = addr_q;

  // Fetch FSM next state and slot update.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    mru_d     = mru_q;
    target_d  = target_q;
    discard_d = discard_q;
    addr_d    = addr_q;

    if (any_hit_s) begin
      mru_d = hit_slot_s;
    end else begin
      mru_d = mru_q;
    end

    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (!any_hit_s) begin
          state_d   = S_REQ;
          addr_d    = word_addr_s;
          target_d  = pick_victim(valid_q, mru_q);
          discard_d = 1'b0;
        end else if (!next_held_s) begin
          state_d   = S_REQ;
          addr_d    = next_addr_s;
          target_d  = ~hit_slot_s;
          discard_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        target_d = fill_slot_s;
        if (flush) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
        if (mem_ack) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          // A fill requested before a flush belongs to the old program.
          if (!discard_q && !flush) begin
            for (int i = 0; i < 2; i++) begin
              if (fill_slot_s == 1'(i)) begin
                valid_d[i] = 1'b1;
                tag_d[i]   = addr_q;
                data_d[i]  = mem_rdata;
              end else begin
                valid_d[i] = valid_q[i];
              end
            end
          end else begin
            valid_d = valid_q;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      valid_d = 2'b00;
      mru_d   = 1'b0;
    end else begin
      valid_d = valid_d;
    end
  end

  // State and slot registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      valid_q   <= 2'b00;
      mru_q     <= 1'b0;
      target_q  <= 1'b0;
      discard_q <= 1'b0;
      addr_q    <= {WADDR_W{1'b0}};
      for (int i = 0; i < 2; i++) begin
        tag_q[i]  <= {WADDR_W{1'b0}};
        data_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      mru_q     <= mru_d;
      target_q  <= target_d;
      discard_q <= discard_d;
      addr_q    <= addr_d;
      for (int i = 0; i < 2; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [PC_W-1:0] pc_prev_q;
  logic [31:0]     hit_count_q;
  logic [31:0]     miss_count_q;
  logic            demand_issue_s;

  assign demand_issue_s = (state_q == S_IDLE) && !flush && !any_hit_s;

  // Saturating hit/miss statistics; cleared by reset only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_prev_q    <= {PC_W{1'b0}};
      hit_count_q  <= 32'h0000_0000;
      miss_count_q <= 32'h0000_0000;
    end else begin
      pc_prev_q <= pc;
      if (instr_valid && (pc != pc_prev_q) && (hit_count_q != 32'hFFFF_FFFF)) begin
        hit_count_q <= hit_count_q + 32'd1;
      end else begin
        hit_count_q <= hit_count_q;
      end
      if (demand_issue_s && (miss_count_q != 32'hFFFF_FFFF)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end else begin
        miss_count_q <= miss_count_q;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
